// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types for the UART transmit path.
//   parity_e   : parity mode encoding carried on parity_type
//   tx_state_e : transmit frame FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE0 = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_parity_gen.sv
// -----------------------------------------------------------------------------
// uart_parity_gen
// Combinational parity generator for one byte.
// Ports:
//   data   in  8  byte to protect
//   mode   in  2  parity mode (uart_pkg::parity_e encoding)
//   parity out 1  parity bit to transmit (odd: total ones odd, even: total even)
//   enable out 1  high when a parity bit belongs in the frame
// -----------------------------------------------------------------------------
module uart_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] mode,
  output logic       parity,
  output logic       enable
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    parity = 1'b0;
    enable = 1'b0;
    case (mode)
      PAR_ODD: begin
        parity = ~^data;
        enable = 1'b1;
      end
      PAR_EVEN: begin
        parity = ^data;
        enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit sequencer: start, 8 data bits LSB first, optional parity, stop.
// Every serial bit lasts CLKS_PER_BIT clock cycles.
// Build option: define UART_TX_STOP2_EN for two stop bits (default: one).
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   tx_valid    in   1  host offers tx_data/parity_type
//   tx_data     in   8  byte to send
//   parity_type in   2  00/11 none, 01 odd, 10 even
//   tx_ready    out  1  high only in IDLE; transfer on tx_valid && tx_ready
//   tx_line     out  1  registered serial output, idles high
//   tx_busy     out  1  high whenever not IDLE
//   tx_done     out  1  one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic [1:0] parity_type,
  output logic       tx_ready,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_STOP2_EN
  localparam logic STOP_LAST = 1'b1;
`else
  localparam logic STOP_LAST = 1'b0;
`endif

  tx_state_e   state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [2:0]  idx_q, idx_n;
  logic        stop_q, stop_n;     // which stop bit is being sent
  logic [7:0]  data_q, data_n;
  logic        par_bit_q, par_bit_n;
  logic        par_en_q, par_en_n;
  logic        line_q, line_n;
  logic        done_q, done_n;
  logic        gen_par, gen_en;
  logic        bit_end;

  uart_parity_gen u_parity_gen (
    .data   (tx_data),
    .mode   (parity_type),
    .parity (gen_par),
    .enable (gen_en)
  );

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    stop_n    = stop_q;
    data_n    = data_q;
    par_bit_n = par_bit_q;
    par_en_n  = par_en_q;
    done_n    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_n   = START;
          cnt_n     = 16'd0;
          data_n    = tx_data;
          par_bit_n = gen_par;
          par_en_n  = gen_en;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = 16'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = 16'd0;
          if (idx_q == 3'd7) begin
            idx_n   = 3'd0;
            stop_n  = 1'b0;
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            idx_n = idx_q + 3'd1;
          end
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = 16'd0;
          stop_n  = 1'b0;
          state_n = STOP;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = 16'd0;
          if (stop_q == STOP_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            stop_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered so the register output
    // changes on the same edge as the state, one cycle after acceptance.
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = data_n[idx_n];
      PARITY:  line_n = par_bit_n;
      default: line_n = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      stop_q    <= 1'b0;
      data_q    <= 8'd0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      line_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      idx_q     <= idx_n;
      stop_q    <= stop_n;
      data_q    <= data_n;
      par_bit_q <= par_bit_n;
      par_en_q  <= par_en_n;
      line_q    <= line_n;
      done_q    <= done_n;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_line  = line_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl with CLKS_PER_BIT=4. A frame-level
// model predicts tx_line/tx_busy/tx_ready/tx_done every cycle; directed tests
// pin frames and done timing with hand-computed literals.
// Define UART_TX_STOP2_EN for both RTL and bench to test two stop bits.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int C = 4;
`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int EXTRA = (NSTOP - 1) * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic       tx_ready, tx_line, tx_busy, tx_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  uart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .parity_type (parity_type),
    .tx_ready    (tx_ready),
    .tx_line     (tx_line),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  // m_t counts cycles since acceptance; bit k of the frame owns cycles
  // 1+k*C .. (k+1)*C. After the last bit the model returns idle with done.
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_t = 0;
  int m_nbits = 0;
  bit m_bits[12];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_t    = 0;
    end else if (m_busy) begin
      m_done = 1'b0;
      m_t++;
      if (m_t > m_nbits * C) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (tx_valid) begin
        int n;
        n = 0;
        m_bits[n++] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[n++] = tx_data[i];
        if (parity_type == 2'b01) m_bits[n++] = ($countones(tx_data) % 2 == 0);
        if (parity_type == 2'b10) m_bits[n++] = ($countones(tx_data) % 2 == 1);
        for (int s = 0; s < NSTOP; s++) m_bits[n++] = 1'b1;
        m_nbits = n;
        m_busy  = 1'b1;
        m_t     = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic m_line;
      m_line = m_busy ? m_bits[(m_t - 1) / C] : 1'b1;
      check("line_busy_ready_done", {28'd0, tx_line, tx_busy, tx_ready, tx_done},
            {28'd0, m_line, m_busy, ~m_busy, m_done});
    end
  end

  // ---------------- directed helpers ----------------
  // Called at a negedge: offers a byte and returns the cycle in which the
  // handshake is visible (cycle 0 of the frame). Leaves valid low afterwards
  // unless hold is set.
  task automatic offer(input logic [7:0] d, input logic [1:0] p, input bit hold,
                       output int acc);
    tx_valid = 1'b1;
    tx_data = d;
    parity_type = p;
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      if (tx_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Starts at the negedge of cycle 1; samples each bit in its second cycle.
  task automatic capture(input string name, input int acc, input int nbits,
                         input logic [11:0] exp_frame, input int exp_done);
    logic [11:0] frame;
    int done_at, done_cnt, rel;
    frame = '0;
    done_at = -1;
    done_cnt = 0;
    for (int r = 0; r < nbits * C + 3; r++) begin
      rel = cyc - acc;
      if (rel >= 2 && (rel - 2) % C == 0 && (rel - 2) / C < nbits)
        frame[(rel - 2) / C] = tx_line;
      if (tx_done) begin
        done_cnt++;
        if (done_at < 0) done_at = rel;
      end
      @(negedge clk);
    end
    check({name, "_frame"}, {20'd0, frame}, {20'd0, exp_frame});
    check({name, "_done_cycle"}, done_at, exp_done);
    check({name, "_done_width"}, done_cnt, 1);
  endtask

  function automatic logic [11:0] add_stop2(input logic [11:0] f, input int nb);
    return (NSTOP == 2) ? (f | (12'd1 << nb)) : f;
  endfunction

  initial begin
    int acc, acc2;
    bit ready_seen;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {28'd0, tx_line, tx_busy, tx_ready, tx_done}, 32'b1010);
    cmp_en = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1. 0xA5 even: parity 0
    offer(8'hA5, 2'b10, 1'b0, acc);
    capture("a5_even", acc, 11 + NSTOP - 1, add_stop2(12'b0_1_0_1010_0101_0, 11), 45 + EXTRA);
    // 2. 0xA5 odd: parity 1; 0x01 even: parity 1
    offer(8'hA5, 2'b01, 1'b0, acc);
    capture("a5_odd", acc, 11 + NSTOP - 1, add_stop2(12'b0_1_1_1010_0101_0, 11), 45 + EXTRA);
    offer(8'h01, 2'b10, 1'b0, acc);
    capture("01_even", acc, 11 + NSTOP - 1, add_stop2(12'b0_1_1_0000_0001_0, 11), 45 + EXTRA);
    // 3. 0x3C without parity, both encodings
    offer(8'h3C, 2'b00, 1'b0, acc);
    capture("3c_none0", acc, 10 + NSTOP - 1, add_stop2(12'b00_1_0011_1100_0, 10), 41 + EXTRA);
    offer(8'h3C, 2'b11, 1'b0, acc);
    capture("3c_none3", acc, 10 + NSTOP - 1, add_stop2(12'b00_1_0011_1100_0, 10), 41 + EXTRA);

    // 4. back-to-back with valid held; data changes mid-frame are ignored
    offer(8'h55, 2'b00, 1'b1, acc);
    tx_data = 8'hAA;
    ready_seen = 1'b0;
    for (int r = 0; r < 200 && (cyc - acc) < 41 + EXTRA; r++) begin
      if (tx_ready) ready_seen = 1'b1;
      @(negedge clk);
    end
    check("b2b_ready_low_in_frame", ready_seen, 0);
    check("b2b_first_done", {tx_done, tx_ready, tx_line}, 3'b111);
    acc2 = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
    check("b2b_second_start", tx_line, 1'b0);
    capture("aa_b2b", acc2, 10 + NSTOP - 1, add_stop2(12'b00_1_1010_1010_0, 10), 41 + EXTRA);

    // 5. reset during data bit 3 (cycles 17..20 of the frame)
    offer(8'hF0, 2'b10, 1'b0, acc);
    while ((cyc - acc) < 18) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_frame", {tx_line, tx_busy, tx_ready, tx_done}, 4'b1010);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    offer(8'hC3, 2'b01, 1'b0, acc);
    capture("c3_odd_after_rst", acc, 11 + NSTOP - 1, add_stop2(12'b0_1_1_1100_0011_0, 11), 45 + EXTRA);

`ifdef UART_TX_STOP2_EN
    // 6. two stop bits: 0xFF even, stop high for 8 cycles
    offer(8'hFF, 2'b10, 1'b0, acc);
    capture("ff_even_stop2", acc, 12, 12'b1_1_0_1111_1111_0, 49);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
